// File: rtl/delay_check_monitor.sv
// Self-checking run monitor: delays the expected stream to match datapath latency,
// counts mismatches on check strobes, and reports pass/fail/timeout under a cycle watchdog.
module delay_check_monitor #(
    parameter int NUM_STAGES = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 100000,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  done,
    input  logic                  fail_req,
    input  logic [DATA_WIDTH-1:0] expected_in,
    input  logic                  check_valid,
    input  logic [DATA_WIDTH-1:0] observed,
    output logic [DATA_WIDTH-1:0] delayed_out,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic                  busy,
    output logic [15:0]           err_count,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_pass;
    logic             r_fail;
    logic             r_timeout;
    logic             r_busy;
    logic [15:0]      r_err_count;
    logic [CNT_W-1:0] r_cycle_count;

    logic             w_mismatch;
    logic [15:0]      w_err_next;
    logic             w_watchdog;

    // The delay line free-runs regardless of run state so alignment never depends on start timing.
    if (NUM_STAGES == 0) begin : g_bypass
        assign delayed_out = expected_in;
    end else begin : g_pipe
        logic [DATA_WIDTH-1:0] r_stage [NUM_STAGES];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < NUM_STAGES; i++) r_stage[i] <= '0;
            end else begin
                r_stage[0] <= expected_in;
                for (int i = 1; i < NUM_STAGES; i++) r_stage[i] <= r_stage[i-1];
            end
        end

        assign delayed_out = r_stage[NUM_STAGES-1];
    end

    assign w_mismatch = check_valid && (observed != delayed_out);
    assign w_err_next = (w_mismatch && (r_err_count != 16'hFFFF)) ? r_err_count + 16'd1
                                                                   : r_err_count;
    assign w_watchdog = (r_cycle_count == CNT_W'(TIMEOUT - 1));

    // cycle_count only advances while the run continues, so it freezes on the deciding cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
            r_busy        <= 1'b0;
            r_err_count   <= '0;
            r_cycle_count <= '0;
        end else if (start) begin
            r_state       <= S_RUN;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
            r_busy        <= 1'b1;
            r_err_count   <= '0;
            r_cycle_count <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_err_count <= w_err_next;
                    if (fail_req) begin
                        r_state <= S_FAIL;
                        r_fail  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (done) begin
                        r_busy <= 1'b0;
                        if (w_err_next == 16'd0) begin
                            r_state <= S_PASS;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= S_FAIL;
                            r_fail  <= 1'b1;
                        end
                    end else if (w_watchdog) begin
                        r_state   <= S_FAIL;
                        r_fail    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cycle_count <= r_cycle_count + 1'b1;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign busy        = r_busy;
    assign err_count   = r_err_count;
    assign cycle_count = r_cycle_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_delay_check_monitor.sv
// Randomized bench for delay_check_monitor: a shift-history model predicts delayed_out and
// a per-run outcome model predicts the terminal pass/fail record popped by a monitor.
module tb_delay_check_monitor;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int TMO = 40;
    localparam int CW  = 32;
    localparam int RW  = 3 + 16 + CW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          done = 1'b0;
    logic          fail_req = 1'b0;
    logic          check_valid = 1'b0;
    logic [W-1:0]  expected_in = '0;
    logic [W-1:0]  observed = '0;

    logic [W-1:0]  delayed_out;
    logic          pass, fail, timeout, busy;
    logic [15:0]   err_count;
    logic [CW-1:0] cycle_count;
    logic [1:0]    dbg_state;

    logic [W-1:0]  delayed_out0;
    logic          pass0, fail0, timeout0, busy0;
    logic [15:0]   err_count0;
    logic [CW-1:0] cycle_count0;
    logic [1:0]    dbg_state0;

    int n_checks = 0;
    int n_errors = 0;

    logic [RW-1:0] exp_q[$];
    logic [W-1:0]  hist[$];
    int            err_pos[$];
    logic          prev_term = 1'b0;

    delay_check_monitor #(.NUM_STAGES(N), .DATA_WIDTH(W), .TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .fail_req(fail_req),
        .expected_in(expected_in), .check_valid(check_valid), .observed(observed),
        .delayed_out(delayed_out), .pass(pass), .fail(fail), .timeout(timeout), .busy(busy),
        .err_count(err_count), .cycle_count(cycle_count), .dbg_state(dbg_state)
    );

    delay_check_monitor #(.NUM_STAGES(0), .DATA_WIDTH(W), .TIMEOUT(TMO), .CNT_W(CW)) dut0 (
        .clk(clk), .reset(reset), .start(start), .done(done), .fail_req(fail_req),
        .expected_in(expected_in), .check_valid(check_valid), .observed(observed),
        .delayed_out(delayed_out0), .pass(pass0), .fail(fail0), .timeout(timeout0), .busy(busy0),
        .err_count(err_count0), .cycle_count(cycle_count0), .dbg_state(dbg_state0)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference delay model: the last N sampled inputs, oldest first.
    initial begin
        for (int i = 0; i < N; i++) hist.push_back('0);
    end

    always @(posedge clk) begin
        if (!reset) begin
            hist = {};
            for (int i = 0; i < N; i++) hist.push_back('0);
        end else begin
            hist.push_back(expected_in);
            void'(hist.pop_front());
        end
    end

    function automatic logic [W-1:0] exp_delayed();
        return reset ? hist[0] : '0;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [RW-1:0] e;
        logic          term;
        check("delayed_out", delayed_out, exp_delayed());
        check("delayed_out_n0", delayed_out0, expected_in);
        term = pass | fail;
        if (term && !prev_term) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {pass, fail}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                check("res_pass", pass, e[RW-1]);
                check("res_fail", fail, e[RW-2]);
                check("res_timeout", timeout, e[RW-3]);
                check("res_err_count", err_count, e[CW+15:CW]);
                check("res_cycle_count", cycle_count, e[CW-1:0]);
                check("res_busy", busy, 1'b0);
            end
        end
        prev_term = term;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 6 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            check("result_wait_expired", exp_q.size(), 0);
            exp_q = {};
        end
    endtask

    task automatic push_result(input logic p, input logic f, input logic t,
                               input int errs, input int k);
        exp_q.push_back({p, f, t, 16'(errs), CW'(k)});
    endtask

    // One run: mismatches on cycles listed in err_pos, done/fail_req at given RUN-cycle
    // index (-1 = never). Outcome follows the run rules evaluated cycle by cycle.
    task automatic do_run(input int done_at, input int freq_at);
        logic [W-1:0] exp_d;
        int  errs;
        int  k;
        bit  over;
        bit  mism;
        expected_in = W'($urandom);
        check_valid = 1'b1;
        observed    = ~exp_delayed();
        done        = 1'b0;
        fail_req    = 1'b0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        errs  = 0;
        k     = 0;
        over  = 0;
        while (!over) begin
            if (k == 0) begin
                check("run_busy", busy, 1'b1);
                check("run_pass_clr", pass, 1'b0);
                check("run_fail_clr", fail, 1'b0);
                check("run_timeout_clr", timeout, 1'b0);
                check("run_err_clr", err_count, 16'd0);
                check("run_cycle_clr", cycle_count, '0);
            end
            exp_d       = exp_delayed();
            expected_in = W'($urandom);
            mism = 0;
            foreach (err_pos[i]) if (err_pos[i] == k) mism = 1;
            if (mism) begin
                check_valid = 1'b1;
                observed    = exp_d ^ W'($urandom_range(1, 65535));
            end else begin
                check_valid = ($urandom_range(0, 3) != 0);
                observed    = check_valid ? exp_d : W'($urandom);
            end
            done     = (k == done_at);
            fail_req = (k == freq_at);
            if (mism && errs < 65535) errs++;
            if (fail_req) begin
                push_result(1'b0, 1'b1, 1'b0, errs, k);
                over = 1;
            end else if (done) begin
                push_result(errs == 0, errs != 0, 1'b0, errs, k);
                over = 1;
            end else if (k == TMO - 1) begin
                push_result(1'b0, 1'b1, 1'b1, errs, k);
                over = 1;
            end
            tick();
            k++;
        end
        done        = 1'b0;
        fail_req    = 1'b0;
        check_valid = 1'b0;
        wait_drain();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pass", pass, 1'b0);
        check("rst_fail", fail, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err_count, 16'd0);
        check("rst_cycle", cycle_count, '0);
        check("rst_delayed", delayed_out, '0);
        reset = 1'b1;

        // Delay line with a ramp 1,2,3,... (checked every cycle by the monitor)
        for (int i = 1; i <= 12; i++) begin
            expected_in = W'(i);
            tick();
        end

        // Clean run of 20 checked cycles, then done
        err_pos = {};
        do_run(20, -1);
        // Terminal state ignores further checks and done
        check_valid = 1'b1;
        observed    = ~exp_delayed();
        done        = 1'b1;
        repeat (3) tick();
        done = 1'b0; check_valid = 1'b0;
        check("pass_hold", pass, 1'b1);
        check("pass_err_frozen", err_count, 16'd0);
        check("pass_cycle_frozen", cycle_count, CW'(20));

        // Three corrupted checks then done
        err_pos = {3, 9, 15};
        do_run(20, -1);

        // Only mismatch coincides with done
        err_pos = {8};
        do_run(8, -1);

        // Watchdog, then a late done is ignored
        err_pos = {};
        do_run(-1, -1);
        done = 1'b1;
        repeat (2) tick();
        done = 1'b0;
        check("wd_fail_hold", fail, 1'b1);
        check("wd_pass_low", pass, 1'b0);
        check("wd_timeout_hold", timeout, 1'b1);
        check("wd_cycle", cycle_count, CW'(TMO - 1));

        // Forced failure together with done, then restart clears everything
        err_pos = {};
        do_run(5, 5);
        do_run(12, -1);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            int n_e;
            int d_at;
            int f_at;
            err_pos = {};
            n_e = $urandom_range(0, 3);
            for (int i = 0; i < n_e; i++) err_pos.push_back($urandom_range(0, 34));
            d_at = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 35);
            f_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 35) : -1;
            do_run(d_at, f_at);
        end

        // Asynchronous reset in the middle of a run
        err_pos = {};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check_valid = 1'b1;
            observed    = exp_delayed();
            expected_in = W'($urandom_range(1, 65535));
            tick();
        end
        #2;
        reset = 1'b0;
        #1;
        check("arst_pass", pass, 1'b0);
        check("arst_fail", fail, 1'b0);
        check("arst_timeout", timeout, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_err", err_count, 16'd0);
        check("arst_cycle", cycle_count, '0);
        check("arst_delayed", delayed_out, '0);
        expected_in = '0;
        check_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        check("post_rst_delayed", delayed_out, '0);
        done = 1'b1;
        repeat (2) tick();
        done = 1'b0;
        repeat (2) tick();
        check("post_rst_idle_busy", busy, 1'b0);
        check("post_rst_idle_pass", pass, 1'b0);
        check("post_rst_idle_fail", fail, 1'b0);
        check("no_leftover_results", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/delay_check_monitor.md
Name: delay_check_monitor

Overview:
- Self-checking monitor block for accelerator simulation and on-chip debug.
- Delays an expected-value stream through a configurable register pipeline, so it lines up with the datapath latency.
- Compares the delayed value against the observed datapath value whenever a check strobe is asserted.
- Tracks the overall run result (pass, fail or timeout) with a cycle watchdog.

Parameters:
- NUM_STAGES, 4: number of register stages in the expected-value delay line; 0 = combinational pass-through.
- DATA_WIDTH, 16: width of the expected and observed values.
- TIMEOUT, 100000: number of RUN cycles without done before the run is declared failed; must be at least 1.
- CNT_W, 32: width of the cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins (or restarts) a run.
- done  in  1  the design under test has finished; sampled only in RUN.
- fail_req  in  1  external request to force a failure; sampled only in RUN.
- expected_in  in  DATA_WIDTH  expected value, undelayed.
- check_valid  in  1  compare observed against delayed_out this cycle.
- observed  in  DATA_WIDTH  value produced by the datapath.
- delayed_out  out  DATA_WIDTH  expected_in delayed by NUM_STAGES cycles.
- pass  out  1  run finished with no errors; sticky.
- fail  out  1  run failed; sticky.
- timeout  out  1  the failure was caused by the watchdog.
- busy  out  1  high while in RUN.
- err_count  out  16  number of mismatches in the current run; saturates at 0xFFFF.
- cycle_count  out  CNT_W  number of cycles spent in RUN.

Behaviour:
- Reset (reset=0, asynchronous):
  - All delay stages are cleared to 0.
  - State goes to IDLE.
  - pass, fail, timeout, busy, err_count and cycle_count all go to 0.
  - Reset in the middle of a run aborts it immediately; no pass or fail is reported.
- Delay line:
  - Free-running shift register, not gated by state or by check_valid.
  - With NUM_STAGES=N, delayed_out(t) = expected_in(t−N).
  - With N=0, delayed_out = expected_in combinationally.
- States: IDLE, RUN, PASS, FAIL. start takes priority in every state.
  - start in any state: next state is RUN; cycle_count, err_count, pass, fail and timeout are cleared.
  - RUN: cycle_count increments by 1 every cycle, starting from 0 on the first RUN cycle.
  - RUN: a mismatch is check_valid=1 with observed != delayed_out. Each mismatch increments err_count, saturating at 0xFFFF.
  - RUN priority, highest first:
    1. fail_req=1: go to FAIL.
    2. done=1: go to PASS if err_count, including any mismatch in this same cycle, is 0; otherwise go to FAIL.
    3. cycle_count == TIMEOUT−1 (and no done): go to FAIL with timeout=1.
  - PASS and FAIL are terminal: they hold until start or reset. The counters freeze; checks and done are ignored.
- Outputs:
  - pass=1 exactly in PASS.
  - fail=1 exactly in FAIL.
  - busy=1 exactly in RUN.
  - All outputs are registered; pass or fail rises one cycle after the deciding event is sampled.
- cycle_count does not wrap, because the watchdog fires before the counter can overflow.

Test Plan:
- Delay line: NUM_STAGES=4, drive expected_in = 1, 2, 3, … on consecutive cycles after reset → delayed_out reads 0 for 4 cycles, then 1, 2, 3, … exactly 4 cycles late.
- Clean run: start; for 20 cycles set check_valid=1 and observed equal to expected_in from 4 cycles earlier; then pulse done → pass=1 on the next cycle, fail=0, err_count=0, busy=0.
- Mismatch: same as the clean run, but observed is corrupted on 3 checked cycles; then done → fail=1, timeout=0, err_count=3. A mismatch in the same cycle as done with no prior errors → fail=1.
- Watchdog: TIMEOUT=10; start and never assert done → fail=1 and timeout=1 after 10 RUN cycles, cycle_count=9; a later done is ignored.
- Forced failure and restart: in RUN, assert fail_req together with done → FAIL. Then pulse start → pass, fail and counters cleared, busy=1.
- Asynchronous reset: assert reset=0 in mid-run, between clock edges → all outputs are 0 immediately; after release, state is IDLE and delayed_out=0.
